// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (A: CPU, B: loader/DMA), the arbiter
// and a single-port synchronous memory.
//   a_*/b_*   : request (req, wren, wmask, addr, wdata) and response
//               (gnt, rvalid, rdata, err) per requester port
//   mem_*     : memory strobe, byte enables, write data, word address,
//               and read data (valid one cycle after the address)
// Modports:
//   slave  - arbiter view (takes requests, drives grants/responses/memory)
//   master - requester/memory view (the opposite directions)
interface mem_arbiter_if #(
  parameter int unsigned AW = 13
);
  logic          a_req;
  logic          a_wren;
  logic [3:0]    a_wmask;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [31:0]   a_rdata;
  logic          a_err;

  logic          b_req;
  logic          b_wren;
  logic [3:0]    b_wmask;
  logic [31:0]   b_addr;
  logic [31:0]   b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [31:0]   b_rdata;
  logic          b_err;

  logic          mem_wren;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  modport slave (
    input  a_req, a_wren, a_wmask, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata, a_err,
    input  b_req, b_wren, b_wmask, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output mem_wren, mem_wmask, mem_wdata, mem_addr,
    input  mem_rdata
  );

  modport master (
    output a_req, a_wren, a_wmask, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    output b_req, b_wren, b_wmask, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  mem_wren, mem_wmask, mem_wdata, mem_addr,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave: requester ports A/B and the memory side
// Parameters:
//   AW    - memory word-address width (window = 4*2^AW bytes)
//   BASE  - byte base address of the memory window
// Behaviour: at most one grant per cycle, combinational from the requests
// and a 1-bit priority state; every grant yields exactly one rvalid pulse on
// the granted port one cycle later. Out-of-window accesses are granted but
// never write memory and respond with err=1, rdata=0.
module mem_arbiter #(
  parameter int unsigned AW   = 13,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input logic          clk,
  input logic          rstn,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  pri_e        pri_q, pri_d;
  logic        rsp_valid_q;
  port_e       rsp_port_q;
  logic        rsp_err_q;
  logic        rsp_wr_q;

  logic        gnt_a, gnt_b, any_gnt;
  logic        sel_wren;
  logic [3:0]  sel_wmask;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_win;
  logic [31:0] rsp_data;
  logic        unused_addr_lsb;

  // Grants are held off while reset is asserted so no access can be
  // accepted (or reach memory) during reset.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rstn) begin
      if (bus.a_req && bus.b_req) begin
        gnt_a = (pri_q == PRI_A);
        gnt_b = (pri_q == PRI_B);
      end else begin
        gnt_a = bus.a_req;
        gnt_b = bus.b_req;
      end
    end
    any_gnt = gnt_a | gnt_b;

    // The port just served loses priority; idle cycles keep the state.
    pri_d = pri_q;
    if (gnt_a) begin
      pri_d = PRI_B;
    end else if (gnt_b) begin
      pri_d = PRI_A;
    end
  end

  always_comb begin
    if (gnt_b) begin
      sel_wren  = bus.b_wren;
      sel_wmask = bus.b_wmask;
      sel_addr  = bus.b_addr;
      sel_wdata = bus.b_wdata;
    end else begin
      sel_wren  = bus.a_wren;
      sel_wmask = bus.a_wmask;
      sel_addr  = bus.a_addr;
      sel_wdata = bus.a_wdata;
    end
    in_win = (sel_addr[31:AW+2] == BASE[31:AW+2]);
  end

  // Byte offset within a word plays no part in word addressing.
  assign unused_addr_lsb = ^sel_addr[1:0];

  assign bus.a_gnt     = gnt_a;
  assign bus.b_gnt     = gnt_b;
  assign bus.mem_wren  = any_gnt & sel_wren & in_win;
  assign bus.mem_wmask = any_gnt ? sel_wmask : '0;
  assign bus.mem_addr  = sel_addr[AW+1:2];
  assign bus.mem_wdata = sel_wdata;

  // Response context is captured at grant so requesters may change their
  // request signals as soon as they see gnt.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pri_q       <= PRI_A;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_A;
      rsp_err_q   <= 1'b0;
      rsp_wr_q    <= 1'b0;
    end else begin
      pri_q       <= pri_d;
      rsp_valid_q <= any_gnt;
      if (any_gnt) begin
        rsp_port_q <= gnt_b ? PORT_B : PORT_A;
        rsp_err_q  <= ~in_win;
        rsp_wr_q   <= sel_wren;
      end
    end
  end

  // Only an in-window read returns memory data; writes and errors read 0.
  assign rsp_data = (rsp_valid_q && !rsp_err_q && !rsp_wr_q) ? bus.mem_rdata : '0;

  assign bus.a_rvalid = rsp_valid_q & (rsp_port_q == PORT_A);
  assign bus.b_rvalid = rsp_valid_q & (rsp_port_q == PORT_B);
  assign bus.a_err    = bus.a_rvalid & rsp_err_q;
  assign bus.b_err    = bus.b_rvalid & rsp_err_q;
  assign bus.a_rdata  = bus.a_rvalid ? rsp_data : '0;
  assign bus.b_rdata  = bus.b_rvalid ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives both requester ports, models a
// synchronous-read memory, and keeps an independent reference copy of the
// memory contents. Expected responses are queued at grant time and checked
// when the DUT answers.
module tb_mem_arbiter;

  localparam int unsigned AW    = 13;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic        port;   // 0 = A, 1 = B
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk;
  logic        rstn;
  int          total;
  int          bad;
  rsp_t        exp_q[$];
  rsp_t        mon_e;
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.AW(AW), .BASE(BASE)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Memory: byte-masked write, registered read (one-cycle latency).
  always @(posedge clk) begin
    if (bus.mem_wren) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (bus.mem_wmask[k]) mem[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
      end
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  function automatic logic [31:0] seed(input int unsigned i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    total++;
    assert (obs === expd) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a_gnt",     32'(bus.a_gnt),     32'd0);
    chk("rst_b_gnt",     32'(bus.b_gnt),     32'd0);
    chk("rst_a_rvalid",  32'(bus.a_rvalid),  32'd0);
    chk("rst_b_rvalid",  32'(bus.b_rvalid),  32'd0);
    chk("rst_a_err",     32'(bus.a_err),     32'd0);
    chk("rst_b_err",     32'(bus.b_err),     32'd0);
    chk("rst_mem_wren",  32'(bus.mem_wren),  32'd0);
    chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
  endtask

  // One cycle of stimulus: drive both ports at the falling edge, check the
  // combinational grant and memory-side outputs, and queue the response.
  task automatic cyc(
    input logic ar, input logic aw, input logic [3:0] am, input logic [31:0] aa, input logic [31:0] ad,
    input logic br, input logic bw, input logic [3:0] bm, input logic [31:0] ba, input logic [31:0] bd,
    input logic ega, input logic egb
  );
    logic          s_wr;
    logic [3:0]    s_m;
    logic [31:0]   s_a;
    logic [31:0]   s_d;
    logic          inwin;
    logic [AW-1:0] w;
    rsp_t          e;
    @(negedge clk);
    bus.a_req = ar; bus.a_wren = aw; bus.a_wmask = am; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_wren = bw; bus.b_wmask = bm; bus.b_addr = ba; bus.b_wdata = bd;
    #1;
    chk("a_gnt", 32'(bus.a_gnt), 32'(ega));
    chk("b_gnt", 32'(bus.b_gnt), 32'(egb));
    if (ega || egb) begin
      s_wr  = egb ? bw : aw;
      s_m   = egb ? bm : am;
      s_a   = egb ? ba : aa;
      s_d   = egb ? bd : ad;
      inwin = ((s_a >> (AW + 2)) == (BASE >> (AW + 2)));
      w     = s_a[AW+1:2];
      chk("mem_wren",  32'(bus.mem_wren),  32'(s_wr && inwin));
      chk("mem_wmask", 32'(bus.mem_wmask), 32'(s_m));
      chk("mem_addr",  32'(bus.mem_addr),  32'(w));
      if (s_wr && inwin) chk("mem_wdata", bus.mem_wdata, s_d);
      e.port  = egb;
      e.err   = !inwin;
      e.rdata = (s_wr || !inwin) ? 32'd0 : ref_mem[w];
      exp_q.push_back(e);
      if (s_wr && inwin) begin
        for (int unsigned k = 0; k < 4; k++) begin
          if (s_m[k]) ref_mem[w][8*k +: 8] = s_d[8*k +: 8];
        end
      end
    end else begin
      chk("idle_mem_wren",  32'(bus.mem_wren),  32'd0);
      chk("idle_mem_wmask", 32'(bus.mem_wmask), 32'd0);
    end
  endtask

  // Response monitor: one cycle after each grant exactly one rvalid must
  // appear on the granted port; otherwise both ports stay quiet.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("a_rvalid", 32'(bus.a_rvalid), 32'(!mon_e.port));
      chk("b_rvalid", 32'(bus.b_rvalid), 32'(mon_e.port));
      if (mon_e.port) begin
        chk("b_rdata",      bus.b_rdata,     mon_e.rdata);
        chk("b_err",        32'(bus.b_err),  32'(mon_e.err));
        chk("a_rdata_idle", bus.a_rdata,     32'd0);
        chk("a_err_idle",   32'(bus.a_err),  32'd0);
      end else begin
        chk("a_rdata",      bus.a_rdata,     mon_e.rdata);
        chk("a_err",        32'(bus.a_err),  32'(mon_e.err));
        chk("b_rdata_idle", bus.b_rdata,     32'd0);
        chk("b_err_idle",   32'(bus.b_err),  32'd0);
      end
    end else begin
      chk("q_a_rvalid", 32'(bus.a_rvalid), 32'd0);
      chk("q_b_rvalid", 32'(bus.b_rvalid), 32'd0);
      chk("q_a_rdata",  bus.a_rdata,       32'd0);
      chk("q_b_rdata",  bus.b_rdata,       32'd0);
      chk("q_a_err",    32'(bus.a_err),    32'd0);
      chk("q_b_err",    32'(bus.b_err),    32'd0);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i]     = seed(i);
      ref_mem[i] = seed(i);
    end
    rstn = 1'b0;
    bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_wmask = 4'hF; bus.a_addr = 32'h100; bus.a_wdata = 32'h1111_1111;
    bus.b_req = 1'b1; bus.b_wren = 1'b1; bus.b_wmask = 4'hF; bus.b_addr = 32'h200; bus.b_wdata = 32'h2222_2222;

    // Reset holds off grants and writes even with both ports requesting.
    @(negedge clk); #1; chk_reset_outputs();
    @(negedge clk); #1; chk_reset_outputs();
    #8 rstn = 1'b1;

    // Both ports reading: strict alternation starting from A.
    cyc(1, 0, 4'h0, 32'h100, 0,  1, 0, 4'h0, 32'h200, 0,  1, 0);
    cyc(1, 0, 4'h0, 32'h100, 0,  1, 0, 4'h0, 32'h200, 0,  0, 1);
    cyc(1, 0, 4'h0, 32'h100, 0,  1, 0, 4'h0, 32'h200, 0,  1, 0);
    cyc(1, 0, 4'h0, 32'h100, 0,  1, 0, 4'h0, 32'h200, 0,  0, 1);
    cyc(0, 0, 4'h0, 32'h0,   0,  0, 0, 4'h0, 32'h0,   0,  0, 0);

    // Partial-mask write followed immediately by a read of the same word.
    cyc(1, 1, 4'b0101, 32'h10, 32'hDEAD_BEEF,  0, 0, 4'h0, 32'h0, 0,  1, 0);
    cyc(1, 0, 4'h0,    32'h10, 0,              0, 0, 4'h0, 32'h0, 0,  1, 0);

    // Out-of-window write and read from B: granted, no write, err response.
    cyc(0, 0, 4'h0, 32'h0, 0,  1, 1, 4'hF, 32'h1000_1000, 32'hCAFE_F00D,  0, 1);
    cyc(0, 0, 4'h0, 32'h0, 0,  1, 0, 4'h0, 32'hFFFF_FFFC, 0,              0, 1);

    // B alone for three cycles, then contention: A wins, then alternation.
    cyc(0, 0, 4'h0, 32'h0,  0,  1, 0, 4'h0, 32'h20, 0,  0, 1);
    cyc(0, 0, 4'h0, 32'h0,  0,  1, 0, 4'h0, 32'h24, 0,  0, 1);
    cyc(0, 0, 4'h0, 32'h0,  0,  1, 0, 4'h0, 32'h28, 0,  0, 1);
    cyc(1, 0, 4'h0, 32'h30, 0,  1, 0, 4'h0, 32'h34, 0,  1, 0);
    cyc(1, 0, 4'h0, 32'h30, 0,  1, 0, 4'h0, 32'h34, 0,  0, 1);

    // Window edges, byte-offset bits ignored, back-to-back on one port.
    cyc(1, 1, 4'hF, 32'h7FFC, 32'h0BAD_C0DE,  0, 0, 4'h0, 32'h0, 0,  1, 0);
    cyc(1, 0, 4'h0, 32'h7FFF, 0,              0, 0, 4'h0, 32'h0, 0,  1, 0);
    cyc(1, 1, 4'hF, 32'h8000, 32'h5555_AAAA,  0, 0, 4'h0, 32'h0, 0,  1, 0);
    cyc(1, 0, 4'h0, 32'h0,    0,              0, 0, 4'h0, 32'h0, 0,  1, 0);
    cyc(1, 0, 4'h0, 32'h103,  0,              0, 0, 4'h0, 32'h0, 0,  1, 0);
    cyc(0, 0, 4'h0, 32'h0,    0,              1, 1, 4'b1000, 32'h7FFC, 32'h7700_0000,  0, 1);
    cyc(1, 0, 4'h0, 32'h7FFC, 0,              0, 0, 4'h0, 32'h0, 0,  1, 0);

    // Reset right after an A read is granted: its response must be dropped,
    // and arbitration restarts from PRI_A although B would have been next.
    cyc(1, 0, 4'h0, 32'h104, 0,  0, 0, 4'h0, 32'h0, 0,  1, 0);
    @(posedge clk);
    rstn = 1'b0;
    exp_q.delete();
    bus.a_req = 1'b1; bus.a_wren = 1'b1; bus.a_wmask = 4'hF;
    bus.b_req = 1'b1; bus.b_wren = 1'b1; bus.b_wmask = 4'hF;
    #1; chk_reset_outputs();
    @(negedge clk); #1; chk_reset_outputs();
    @(negedge clk); #1; chk_reset_outputs();
    #8 rstn = 1'b1;
    cyc(1, 0, 4'h0, 32'h100, 0,  1, 0, 4'h0, 32'h200, 0,  1, 0);
    cyc(1, 0, 4'h0, 32'h100, 0,  1, 0, 4'h0, 32'h200, 0,  0, 1);
    cyc(0, 0, 4'h0, 32'h0,   0,  0, 0, 4'h0, 32'h0,   0,  0, 0);
    cyc(0, 0, 4'h0, 32'h0,   0,  0, 0, 4'h0, 32'h0,   0,  0, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13, giving the memory word-address width.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, giving the byte base address of the memory window; the window size is 4*2^AW bytes.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 a_req  in  1  port A (CPU) access request.
REQ-006 a_wren  in  1  port A write (1) or read (0).
REQ-007 a_wmask  in  4  port A byte-write enables.
REQ-008 a_addr  in  32  port A byte address.
REQ-009 a_wdata  in  32  port A write data.
REQ-010 a_gnt  out  1  port A request accepted this cycle.
REQ-011 a_rvalid  out  1  port A response valid.
REQ-012 a_rdata  out  32  port A read data.
REQ-013 a_err  out  1  port A response is an out-of-window error; qualified by a_rvalid.
REQ-014 b_req, b_wren, b_wmask, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: port B (loader/DMA), widths and meanings identical to port A.
REQ-015 mem_wren  out  1  memory write strobe.
REQ-016 mem_wmask  out  4  memory byte enables.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_addr  out  AW  memory word address, taken from byte address bits [AW+1:2].
REQ-019 mem_rdata  in  32  memory read data, valid one cycle after the address is presented.

Function
REQ-020 SHALL grant at most one port per cycle; a grant is combinational from the req inputs and the priority state.
REQ-021 SHALL keep a 1-bit priority state, PRI_A or PRI_B, naming the port that wins when both request.
- PRI_A, with both ports requesting -> grant A; next state PRI_B.
- PRI_B, with both ports requesting -> grant B; next state PRI_A.
- Only one port requesting -> grant that port; next state favours the other port.
- No requests -> state is unchanged.
REQ-022 SHALL drive mem_addr, mem_wdata and mem_wmask from the granted port in the same cycle; mem_wren = granted port's wren AND the address is in the window.
REQ-023 With no grant, SHALL hold mem_wren=0 and mem_wmask=0; mem_addr and mem_wdata are don't-care.
REQ-024 In-window test: addr[31:AW+2] == BASE[31:AW+2]; addr[1:0] is ignored.
REQ-025 An out-of-window access SHALL still be granted, SHALL NOT write memory, and SHALL return x_err=1 and x_rdata=0.
REQ-026 Every granted access, read or write, SHALL produce exactly one x_rvalid pulse on the granted port exactly one cycle after the grant.
REQ-027 x_rdata SHALL equal mem_rdata for an in-window read, 0 for a write, and 0 when x_rvalid=0.
REQ-028 Response routing SHALL use registered state (rsp_port, rsp_valid, rsp_err, rsp_wr) captured at grant, so request changes after grant do not affect the response.
REQ-029 Back-to-back grants, alternating or to the same port, SHALL sustain one access per cycle with no bubble.
REQ-030 A requester SHALL hold its request signals stable until it sees x_gnt; the arbiter does not buffer requests.

Reset
REQ-031 While rstn=0: priority=PRI_A, rsp_valid=0, a_rvalid=b_rvalid=0, a_err=b_err=0, a_gnt=b_gnt=0, mem_wren=0, mem_wmask=0.
REQ-032 Reset asserted mid-access SHALL drop any pending response, so no rvalid appears after rstn rises.
REQ-033 In the first cycle after rstn rises, SHALL arbitrate normally from PRI_A.

Verification
REQ-034 Both ports hold read requests to 0x100 (A) and 0x200 (B) for 4 cycles -> grants A,B,A,B; rvalids arrive one cycle later with mem[0x40] and mem[0x80] respectively.
REQ-035 A writes 0xDEADBEEF to 0x10 with mask 4'b0101, then reads 0x10 next cycle -> the read returns the old word with bytes 0 and 2 replaced (0xEF, 0xAD); A sees rvalid on both cycles with err=0.
REQ-036 B writes to 0x1000_1000 with BASE=0 and AW=13 -> b_gnt=1, mem_wren=0, and next cycle b_rvalid=1, b_err=1, b_rdata=0.
REQ-037 Only B requests, continuously for 3 cycles -> 3 grants and 3 rvalids to B, and a_gnt stays 0; then both request -> A wins first.
REQ-038 rstn is pulled low in the cycle after an A read is granted -> a_rvalid is never asserted, and all outputs match REQ-031 until the next grant.
